// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: XLEN-generic RISC-V immediate generator with a valid/ready
// handshake, one result register plus one skid register (EMPTY/ONE/FULL),
// tag pass-through and a saturating count of delivered illegal results.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      INSTR,
    input  logic [TAG_W-1:0] TAG_IN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  IMM,
    output logic [2:0]       IMM_TYPE,
    output logic             ILLEGAL,
    output logic [TAG_W-1:0] TAG_OUT,
    output logic [CNT_W-1:0] ILLEGAL_CNT
);

    localparam logic [2:0] T_I     = 3'd0;
    localparam logic [2:0] T_S     = 3'd1;
    localparam logic [2:0] T_B     = 3'd2;
    localparam logic [2:0] T_U     = 3'd3;
    localparam logic [2:0] T_J     = 3'd4;
    localparam logic [2:0] T_SHAMT = 3'd5;
    localparam logic [2:0] T_CSR   = 3'd6;
    localparam logic [2:0] T_NONE  = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_imm_r;
    logic [2:0]        out_type_r;
    logic              out_ill_r;
    logic [TAG_W-1:0]  out_tag_r;
    logic [XLEN-1:0]   skid_imm_r;
    logic [2:0]        skid_type_r;
    logic              skid_ill_r;
    logic [TAG_W-1:0]  skid_tag_r;
    logic [CNT_W-1:0]  cnt_r;

    logic [XLEN-1:0]   dec_imm_s;
    logic [2:0]        dec_type_s;
    logic              dec_ill_s;
    logic [6:0]        opcode_s;
    logic [2:0]        funct3_s;
    logic              in_xfer_s;
    logic              out_xfer_s;

    assign opcode_s   = INSTR[6:0];
    assign funct3_s   = INSTR[14:12];
    assign in_xfer_s  = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign IMM         = out_imm_r;
    assign IMM_TYPE    = out_type_r;
    assign ILLEGAL     = out_ill_r;
    assign TAG_OUT     = out_tag_r;
    assign ILLEGAL_CNT = cnt_r;

    // Decode the immediate and its format from the raw instruction word.
    always_comb begin
        dec_imm_s  = '0;
        dec_type_s = T_NONE;
        dec_ill_s  = 1'b0;
        case (opcode_s)
            7'b0000011, 7'b1100111: begin
                dec_imm_s  = XLEN'($signed(INSTR[31:20]));
                dec_type_s = T_I;
            end
            7'b0010011: begin
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    dec_type_s = T_SHAMT;
                    // INSTR[30] selects arithmetic shift and is not part of the amount
                    if (XLEN == 64) begin
                        dec_imm_s = XLEN'(INSTR[25:20]);
                    end else begin
                        dec_imm_s = XLEN'(INSTR[24:20]);
                    end
                end else begin
                    dec_imm_s  = XLEN'($signed(INSTR[31:20]));
                    dec_type_s = T_I;
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                        dec_imm_s  = XLEN'(INSTR[24:20]);
                        dec_type_s = T_SHAMT;
                    end else begin
                        dec_imm_s  = XLEN'($signed(INSTR[31:20]));
                        dec_type_s = T_I;
                    end
                end else begin
                    dec_ill_s = 1'b1;
                end
            end
            7'b1110011: begin
                if ((funct3_s == 3'b101) || (funct3_s == 3'b110) || (funct3_s == 3'b111)) begin
                    dec_imm_s  = XLEN'(INSTR[19:15]);
                    dec_type_s = T_CSR;
                end else begin
                    dec_imm_s  = XLEN'($signed(INSTR[31:20]));
                    dec_type_s = T_I;
                end
            end
            7'b0100011: begin
                dec_imm_s  = XLEN'($signed({INSTR[31:25], INSTR[11:7]}));
                dec_type_s = T_S;
            end
            7'b1100011: begin
                dec_imm_s  = XLEN'($signed({INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0}));
                dec_type_s = T_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm_s  = XLEN'($signed({INSTR[31:12], 12'd0}));
                dec_type_s = T_U;
            end
            7'b1101111: begin
                dec_imm_s  = XLEN'($signed({INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0}));
                dec_type_s = T_J;
            end
            7'b0110011: begin
                dec_ill_s = 1'b0;
            end
            7'b0111011: begin
                dec_ill_s = (XLEN == 64) ? 1'b0 : 1'b1;
            end
            default: begin
                dec_ill_s = 1'b1;
            end
        endcase
    end

    // Two-entry buffer FSM, registered handshake outputs and illegal counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_imm_r   <= '0;
            out_type_r  <= T_NONE;
            out_ill_r   <= 1'b0;
            out_tag_r   <= '0;
            skid_imm_r  <= '0;
            skid_type_r <= T_NONE;
            skid_ill_r  <= 1'b0;
            skid_tag_r  <= '0;
            cnt_r       <= '0;
        end else begin
            if (out_xfer_s && out_ill_r && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        out_imm_r   <= dec_imm_s;
                        out_type_r  <= dec_type_s;
                        out_ill_r   <= dec_ill_s;
                        out_tag_r   <= TAG_IN;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        out_imm_r   <= dec_imm_s;
                        out_type_r  <= dec_type_s;
                        out_ill_r   <= dec_ill_s;
                        out_tag_r   <= TAG_IN;
                    end else if (in_xfer_s) begin
                        skid_imm_r  <= dec_imm_s;
                        skid_type_r <= dec_type_s;
                        skid_ill_r  <= dec_ill_s;
                        skid_tag_r  <= TAG_IN;
                        state_r     <= ST_FULL;
                        in_ready_r  <= 1'b0;
                    end else if (out_xfer_s) begin
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        out_imm_r   <= skid_imm_r;
                        out_type_r  <= skid_type_r;
                        out_ill_r   <= skid_ill_r;
                        out_tag_r   <= skid_tag_r;
                        state_r     <= ST_ONE;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised RV32/RV64 immediate generator with valid/ready handshake and 2-entry skid buffer.
- Sits between instruction fetch/decode and the register-read stage.
- Extends the immediate decode to XLEN-generic output, adds AUIPC, shift-amount and CSR-zimm formats, illegal-opcode flagging, a tag pass-through and a saturating illegal counter.
- Full throughput at 1 instruction/cycle with 1-cycle latency.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64
TAG_W, 8, width of sideband tag carried with each instruction
CNT_W, 16, width of saturating illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  INSTR/TAG_IN valid
in_ready  out  1  block can accept this cycle
INSTR  in  32  raw instruction word
TAG_IN  in  TAG_W  sideband tag (e.g. PC index)
out_valid  out  1  IMM/IMM_TYPE/ILLEGAL/TAG_OUT valid
out_ready  in  1  consumer accepts this cycle
IMM  out  XLEN  generated immediate
IMM_TYPE  out  3  0=I 1=S 2=B 3=U 4=J 5=SHAMT 6=CSR 7=NONE
ILLEGAL  out  1  opcode unsupported for this XLEN
TAG_OUT  out  TAG_W  tag of the presented result
ILLEGAL_CNT  out  CNT_W  count of illegal results delivered, saturating

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Decode is combinational on INSTR and is captured at input transfer.
  - Latency is 1 cycle from input transfer to out_valid.
- Decode, selected by opcode INSTR[6:0]:
  - 0000011 LOAD, 1100111 JALR: I, sext(INSTR[31:20]).
  - 0010011 OP-IMM:
    - funct3 001/101: SHAMT. XLEN=64 → zext(INSTR[25:20]); XLEN=32 → zext(INSTR[24:20]). INSTR[30] is excluded from IMM.
    - Otherwise: I.
  - 0011011 OP-IMM-32, XLEN=64 only:
    - funct3 001/101: SHAMT, zext(INSTR[24:20]).
    - Otherwise: I.
    - With XLEN=32 this opcode is illegal.
  - 1110011 SYSTEM:
    - funct3 101/110/111: CSR, zext(INSTR[19:15]).
    - Otherwise: I.
  - 0100011: S, sext({INSTR[31:25],INSTR[11:7]}).
  - 1100011: B, sext({INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U, sext({INSTR[31:12],12'b0}). Bits above 31 are copies of INSTR[31].
  - 1101111: J, sext({INSTR[31],INSTR[19:12],INSTR[20],INSTR[30:21],1'b0}).
  - 0110011, 0111011 (0111011 only when XLEN=64): NONE, IMM=0, ILLEGAL=0.
  - Any other opcode: NONE, IMM=0, ILLEGAL=1.
  - Every bit of IMM is driven on every path; no latches.
- Buffer FSM, states EMPTY / ONE / FULL:
  - in_ready = (state != FULL). It is a register-derived output with no combinational path from out_ready.
  - out_valid = (state != EMPTY). The output always presents the oldest entry.
  - EMPTY: on input transfer → ONE.
  - ONE:
    - Input and output transfer together → ONE; the new entry replaces the old.
    - Input only → FULL; the new entry goes to the skid slot.
    - Output only → EMPTY.
    - Neither → hold.
  - FULL: on output transfer, the skid entry moves to the output → ONE. No input transfer is possible in FULL.
  - Order is strictly FIFO; no entry is dropped or duplicated.
  - Outputs are stable while out_valid && !out_ready.
- ILLEGAL_CNT:
  - Increments by 1 on an output transfer with ILLEGAL=1.
  - Saturates at 2^CNT_W-1.
- Reset (synchronous, active-high):
  - State=EMPTY, out_valid=0, in_ready=1 on the first cycle after reset.
  - IMM=0, IMM_TYPE=7, ILLEGAL=0, TAG_OUT=0, ILLEGAL_CNT=0.
  - Reset mid-operation discards both entries.
  - in_valid during the reset cycle is ignored.

Test Plan:
- ADDI 0xFFF00093, TAG_IN=0x11, out_ready=1, XLEN=64 → next cycle out_valid=1, IMM=0xFFFFFFFFFFFFFFFF, IMM_TYPE=0, TAG_OUT=0x11.
- SW 0xFE20AE23 → IMM=-4 (0xFFFFFFFFFFFFFFFC), type 1. BEQ 0xFE000CE3 → IMM=-8, type 2, bit0=0.
- SLLI 0x03F09093 → IMM=0x3F, type 5. SRAI 0x43F0D093 → IMM=0x3F, not 0x43F. CSRRWI 0x300FD073 → IMM=0x1F, type 6.
- Back-to-back AUIPC 0x80000017 then LUI 0x12345037 at XLEN=64 → IMM 0xFFFFFFFF80000000 then 0x0000000012345000, one per cycle.
- Backpressure: out_ready=0, 3 back-to-back inputs tagged 1,2,3 → in_ready=0 after the 2nd transfer and tag 3 is held. Raise out_ready → TAG_OUT sequence 1,2,3, no gaps once flowing.
- Illegal: 0xFFFFFFFF → ILLEGAL=1, type 7, IMM=0, ILLEGAL_CNT 0→1. With CNT_W=2, five illegals → count stays 3. Assert reset while FULL → next cycle out_valid=0, in_ready=1, ILLEGAL_CNT=0.
